// File: rtl/chunked_ripple_adder_if.sv
// Handshake/data bundle for chunked_ripple_adder.
// master = operand producer / result consumer, slave = the adder itself.
interface chunked_ripple_adder_if #(
  parameter int WIDTH = 25
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] a;
  logic signed [WIDTH-1:0] b;
  logic                    sub;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] sum;
  logic                    overflow;
  logic                    carry_out;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, overflow, carry_out
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, overflow, carry_out
  );
endinterface

// File: rtl/chunked_ripple_adder.sv
// Multi-cycle signed add/subtract. Ripples CHUNK bits per clock over
// ceil(WIDTH/CHUNK) cycles with the inter-chunk carry held in a register.
// Subtract is done as A + ~B + 1 (the +1 enters as the first carry-in).
// Optional build macro CHUNKED_ADDER_SATURATE_EN clamps the result to the
// signed range on overflow; without it the result wraps modulo 2^WIDTH.
module chunked_ripple_adder #(
  parameter int WIDTH = 25,
  parameter int CHUNK = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  chunked_ripple_adder_if.slave bus
);

  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int CW     = $clog2(NCHUNK) + 1;
  // Operands are zero-padded to a whole number of chunks for the shifter.
  localparam int PW     = NCHUNK * CHUNK;
  localparam int SW     = $clog2(PW) + 1;
  // Number of real bits in the last (possibly partial) chunk.
  localparam int LAST   = WIDTH - (NCHUNK - 1) * CHUNK;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic fa_sum(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic c);
    return (x & y) | (x & c) | (y & c);
  endfunction

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] sum_r;
  logic             ovf_r;
  logic             cout_r;
  logic             out_valid_r;
  logic             in_ready_r;

  logic             last_s;
  logic [SW-1:0]    shamt_s;
  logic [PW-1:0]    a_ext_s;
  logic [PW-1:0]    b_ext_s;
  logic [CHUNK-1:0] a_chunk_s;
  logic [CHUNK-1:0] b_chunk_s;
  logic [CHUNK-1:0] s_chunk_s;
  logic             c_s;
  logic             msb_cin_s;
  logic             cout_last_s;
  logic             chunk_cout_s;
  logic             ovf_s;
  logic [WIDTH-1:0] acc_next_s;
  logic [WIDTH-1:0] result_s;

  // Select the current chunk of both operands and ripple it through full adders.
  always_comb begin
    last_s      = (cnt_r == CW'(NCHUNK - 1));
    shamt_s     = SW'(cnt_r) * SW'(CHUNK);
    a_ext_s     = PW'(a_r);
    b_ext_s     = PW'(b_r);
    a_chunk_s   = CHUNK'(a_ext_s >> shamt_s);
    b_chunk_s   = CHUNK'(b_ext_s >> shamt_s);
    s_chunk_s   = {CHUNK{1'b0}};
    c_s         = carry_r;
    msb_cin_s   = 1'b0;
    cout_last_s = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      // In the last chunk, bit LAST-1 is the MSB of the whole word.
      msb_cin_s    = (i == LAST - 1) ? c_s : msb_cin_s;
      s_chunk_s[i] = fa_sum(a_chunk_s[i], b_chunk_s[i], c_s);
      c_s          = fa_carry(a_chunk_s[i], b_chunk_s[i], c_s);
      cout_last_s  = (i == LAST - 1) ? c_s : cout_last_s;
    end
    // Padding bits beyond WIDTH must not leak into the carry out.
    chunk_cout_s = last_s ? cout_last_s : c_s;
    ovf_s        = msb_cin_s ^ chunk_cout_s;
    acc_next_s   = WIDTH'((PW'(acc_r) & ~(PW'({CHUNK{1'b1}}) << shamt_s)) |
                          (PW'(s_chunk_s) << shamt_s));
  end

  // Final result presented on entry to DONE: wrapped, or clamped on overflow.
  always_comb begin
`ifdef CHUNKED_ADDER_SATURATE_EN
    if (ovf_s) begin
      // No MSB carry-out on overflow means both effective operands were positive.
      result_s = chunk_cout_s ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      result_s = acc_next_s;
    end
`else
    result_s = acc_next_s;
`endif
  end

  // Control FSM plus operand, accumulator and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      carry_r     <= 1'b0;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      acc_r       <= {WIDTH{1'b0}};
      sum_r       <= {WIDTH{1'b0}};
      ovf_r       <= 1'b0;
      cout_r      <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            a_r        <= bus.a;
            b_r        <= bus.sub ? ~bus.b : bus.b;
            carry_r    <= bus.sub;
            acc_r      <= {WIDTH{1'b0}};
            cnt_r      <= {CW{1'b0}};
            state_r    <= BUSY;
            in_ready_r <= 1'b0;
          end
        end
        BUSY: begin
          acc_r   <= acc_next_s;
          carry_r <= chunk_cout_s;
          cnt_r   <= cnt_r + CW'(1);
          if (last_s) begin
            state_r     <= DONE;
            sum_r       <= result_s;
            ovf_r       <= ovf_s;
            cout_r      <= chunk_cout_s;
            out_valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.overflow  = ovf_r;
  assign bus.carry_out = cout_r;

endmodule

// File: tb/tb_chunked_ripple_adder.sv
// Bench for chunked_ripple_adder: four instances (CHUNK 8, 1, 7, 25) share
// one stimulus stream. Table of known vectors, hand sequences for
// backpressure and mid-operation reset, then random operations against an
// integer-arithmetic reference model.
module tb_chunked_ripple_adder;

  localparam int W  = 25;
  localparam int NI = 4;
  localparam longint MAXV = 64'sd16777215;
  localparam longint MINV = -64'sd16777216;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid_d;
  logic sub_d;
  logic out_ready_d;
  logic [W-1:0] a_d;
  logic [W-1:0] b_d;

  logic [NI-1:0] ov_v;
  logic [NI-1:0] ir_v;
  logic [NI-1:0] of_v;
  logic [NI-1:0] co_v;
  logic [W-1:0]  sum_v [NI];

  int n_vec = 0;
  int n_err = 0;
  int lat [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int CHG = (g == 0) ? 8 : (g == 1) ? 1 : (g == 2) ? 7 : 25;
    chunked_ripple_adder_if #(.WIDTH(W)) bus ();
    assign bus.in_valid  = in_valid_d;
    assign bus.a         = a_d;
    assign bus.b         = b_d;
    assign bus.sub       = sub_d;
    assign bus.out_ready = out_ready_d;
    chunked_ripple_adder #(.WIDTH(W), .CHUNK(CHG)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
    assign ov_v[g]  = bus.out_valid;
    assign ir_v[g]  = bus.in_ready;
    assign of_v[g]  = bus.overflow;
    assign co_v[g]  = bus.carry_out;
    assign sum_v[g] = bus.sum;
  end

  // Expected BUSY cycles = ceil(25 / CHUNK) for CHUNK 8, 1, 7, 25.
  function automatic int exp_lat(input int g);
    case (g)
      0:       return 4;
      1:       return 25;
      2:       return 4;
      default: return 1;
    endcase
  endfunction

  typedef struct {
    logic [W-1:0] sum;
    logic         ovf;
    logic         cout;
  } res_t;

  // Reference: exact integer A +/- B, then range check, wrap or clamp.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    res_t m;
    longint sa;
    longint sb;
    longint r;
    longint unsigned ua;
    longint unsigned ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    r  = s ? (sa - sb) : (sa + sb);
    m.ovf  = (r > MAXV) || (r < MINV);
    m.cout = s ? (ua >= ub) : ((ua + ub) >= 64'd33554432);
    m.sum  = W'(r);
`ifdef CHUNKED_ADDER_SATURATE_EN
    if (r > MAXV) m.sum = W'(MAXV);
    else if (r < MINV) m.sum = W'(MINV);
    else m.sum = W'(r);
`endif
    return m;
  endfunction

  task automatic check(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[inst %0d]: got %0h, expected %0h", name, inst, act, exp);
    end
  endtask

  // Accept one operation on all instances, then hold garbage on the inputs
  // (with in_valid high) until every instance shows out_valid.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int n;
    n = 0;
    while (ir_v !== {NI{1'b1}} && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_before_accept", 0, 64'(ir_v), 64'hF);
    a_d = a; b_d = b; sub_d = s;
    in_valid_d = 1'b1; out_ready_d = 1'b0;
    @(posedge clk); #1;
    a_d = W'($urandom); b_d = W'($urandom); sub_d = 1'($urandom);
    for (int g = 0; g < NI; g++) lat[g] = -1;
    for (int e = 1; e <= 40 && ov_v !== {NI{1'b1}}; e++) begin
      @(posedge clk); #1;
      for (int g = 0; g < NI; g++) begin
        if (lat[g] < 0 && ov_v[g] === 1'b1) lat[g] = e;
      end
    end
  endtask

  task automatic release_out();
    out_ready_d = 1'b1;
    @(posedge clk); #1;
    in_valid_d = 1'b0; out_ready_d = 1'b0;
    check("in_ready_after_release", 0, 64'(ir_v), 64'hF);
    check("out_valid_after_release", 0, 64'(ov_v), 64'h0);
  endtask

  task automatic check_all(input res_t m);
    for (int g = 0; g < NI; g++) begin
      check("sum", g, 64'(sum_v[g]), 64'(m.sum));
      check("overflow", g, 64'(of_v[g]), 64'(m.ovf));
      check("carry_out", g, 64'(co_v[g]), 64'(m.cout));
      check("latency", g, 64'(lat[g]), 64'(exp_lat(g)));
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] wrap;
    logic [W-1:0] sat;
    logic         ovf;
    logic         cout;
  } vec_t;

  vec_t tbl [9];
  res_t m;
  logic [W-1:0] ra;
  logic [W-1:0] rb;

  initial begin
    tbl[0] = '{25'd100,       -25'sd30,      1'b0, 25'd70,        25'd70,        1'b0, 1'b1};
    tbl[1] = '{25'd16777215,  25'd1,         1'b0, -25'sd16777216, 25'd16777215, 1'b1, 1'b0};
    tbl[2] = '{-25'sd16777216, 25'd1,        1'b1, 25'd16777215,  -25'sd16777216, 1'b1, 1'b1};
    tbl[3] = '{25'd5,         25'd5,         1'b1, 25'd0,         25'd0,         1'b0, 1'b1};
    tbl[4] = '{25'd3,         25'd4,         1'b0, 25'd7,         25'd7,         1'b0, 1'b0};
    tbl[5] = '{-25'sd1,       -25'sd1,       1'b0, -25'sd2,       -25'sd2,       1'b0, 1'b1};
    tbl[6] = '{25'd0,         25'd0,         1'b1, 25'd0,         25'd0,         1'b0, 1'b1};
    tbl[7] = '{25'd0,         25'd1,         1'b1, -25'sd1,       -25'sd1,       1'b0, 1'b0};
    tbl[8] = '{-25'sd16777216, -25'sd1,      1'b0, 25'd16777215,  -25'sd16777216, 1'b1, 1'b1};

    rst_n = 1'b0; in_valid_d = 1'b0; out_ready_d = 1'b0;
    a_d = '0; b_d = '0; sub_d = 1'b0;
    #12;
    check("reset_out_valid", 0, 64'(ov_v), 64'h0);
    check("reset_overflow", 0, 64'(of_v), 64'h0);
    check("reset_carry_out", 0, 64'(co_v), 64'h0);
    for (int g = 0; g < NI; g++) check("reset_sum", g, 64'(sum_v[g]), 64'h0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_reset", 0, 64'(ir_v), 64'hF);

    // Known vectors.
    for (int v = 0; v < 9; v++) begin
      run_op(tbl[v].a, tbl[v].b, tbl[v].sub);
`ifdef CHUNKED_ADDER_SATURATE_EN
      m.sum = tbl[v].sat;
`else
      m.sum = tbl[v].wrap;
`endif
      m.ovf = tbl[v].ovf;
      m.cout = tbl[v].cout;
      check_all(m);
      release_out();
    end

    // Backpressure: DONE held for 6 cycles with new operands offered.
    run_op(25'd1000, 25'd234, 1'b0);
    a_d = 25'd7; b_d = 25'd8; sub_d = 1'b0; in_valid_d = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 0, 64'(ov_v), 64'hF);
      check("bp_in_ready", 0, 64'(ir_v), 64'h0);
      for (int g = 0; g < NI; g++) check("bp_sum", g, 64'(sum_v[g]), 64'd1234);
    end
    release_out();
    for (int g = 0; g < NI; g++) check("held_sum_after_release", g, 64'(sum_v[g]), 64'd1234);

    // Reset in the middle of an operation (CHUNK=8 instance after 2 chunks).
    a_d = 25'd123456; b_d = 25'd654321; sub_d = 1'b0; in_valid_d = 1'b1;
    @(posedge clk); #1;
    in_valid_d = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 0, 64'(ov_v), 64'h0);
    check("midrst_overflow", 0, 64'(of_v), 64'h0);
    check("midrst_carry_out", 0, 64'(co_v), 64'h0);
    for (int g = 0; g < NI; g++) check("midrst_sum", g, 64'(sum_v[g]), 64'h0);
    #2 rst_n = 1'b1;
    run_op(25'd3, 25'd4, 1'b0);
    m.sum = 25'd7; m.ovf = 1'b0; m.cout = 1'b0;
    check_all(m);
    release_out();

    // Random operations with extra weight on the range extremes.
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 7))
        0:       ra = W'(MAXV);
        1:       ra = W'(MINV);
        default: ra = W'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       rb = W'(MAXV);
        1:       rb = W'(MINV);
        default: rb = W'($urandom);
      endcase
      sub_d = 1'($urandom);
      m = model(ra, rb, sub_d);
      run_op(ra, rb, m.cout === m.cout ? sub_d : 1'b0);
      check_all(m);
      release_out();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/chunked_ripple_adder.md
Name: chunked_ripple_adder

Overview:
- Parametrised, multi-cycle, signed two's-complement add/subtract unit.
- Successor to the team's single-cycle 25-bit ripple-carry adder. Generalised in operand width and gains a subtract mode.
- Ripples CHUNK bits per clock across ceil(WIDTH/CHUNK) cycles and registers the carry between chunks, so long operands meet timing.
- Uses valid/ready handshakes on input and output so it drops into the arithmetic datapath without glue.

Parameters:
- WIDTH, 25, operand and result width in bits; legal range WIDTH >= 2.
- CHUNK, 8, bits summed per clock; legal range 1 <= CHUNK <= WIDTH.
- NCHUNK, derived (local), equals ceil(WIDTH/CHUNK). The last chunk may be partial.

Ports:
- clk, in, 1, single clock; all state updates on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, operands present.
- in_ready, out, 1, block can accept operands.
- a, in, WIDTH, signed operand A.
- b, in, WIDTH, signed operand B.
- sub, in, 1, 0 = A+B, 1 = A-B.
- out_valid, out, 1, result available.
- out_ready, in, 1, consumer accepts result.
- sum, out, WIDTH, signed result, wrapped or saturated.
- overflow, out, 1, signed overflow flag.
- carry_out, out, 1, carry out of bit WIDTH-1; for subtract this means no borrow.

Behaviour:
- States: IDLE, BUSY, DONE. Chunk counter has width clog2(NCHUNK)+1.
- Reset (rst_n low, takes effect immediately, asynchronous):
  - state IDLE, counter 0, carry register 0.
  - sum, overflow, carry_out and out_valid all 0.
  - in_ready is 1 once reset deasserts.
- in_ready is 1 only in IDLE. It is a pure state decode with no combinational path from out_ready.
- Accept (IDLE and in_valid):
  - Latch a into A_r. Latch (sub ? ~b : b) into B_r, and latch sub as the initial chunk carry-in.
  - Clear the sum register, set counter 0, go to BUSY.
- BUSY, each cycle:
  - Chunk k = counter covers bits [k*CHUNK, min((k+1)*CHUNK, WIDTH)-1].
  - Per-bit full adder on those bits: s = a^b^c, cout = majority(a, b, c). The chunk's sum bits are written into the sum register.
  - The carry out of the chunk's top bit goes to the carry register, and the counter increments.
  - After the final chunk (counter == NCHUNK-1) go to DONE.
- Latency: with the accept edge as edge 0, out_valid rises after edge NCHUNK. Throughput is one result per NCHUNK+2 cycles at best.
- Overflow:
  - overflow = c[WIDTH-1] XOR c[WIDTH], the carry into and out of the MSB, both taken from within the final chunk.
  - carry_out = c[WIDTH].
  - This holds for both add and subtract.
- DONE:
  - out_valid = 1; sum, overflow and carry_out are held stable.
  - On out_ready go to IDLE and clear out_valid. Outputs keep their last value until the next result overwrites them.
- in_valid is ignored outside IDLE. Operand changes during BUSY have no effect because operands are registered.
- Reset mid-BUSY or mid-DONE aborts the operation. No partial result is ever presented.
- CHUNK == WIDTH degenerates to one BUSY cycle. CHUNK == 1 is a bit-serial adder with WIDTH BUSY cycles.

Optional Feature:
- Macro: CHUNKED_ADDER_SATURATE_EN.
- Defined: when overflow = 1, sum is clamped on entering DONE. It becomes the max positive value (0 followed by all 1s) if the MSB carry-out is 0, i.e. both effective operands were positive. Otherwise it becomes the min negative value (1 followed by all 0s). The overflow flag still reports 1.
- Undefined: sum wraps modulo 2^WIDTH.
- carry_out is unaffected in both builds.

Test Plan:
- WIDTH=25, CHUNK=8: a=100, b=-30, sub=0 -> sum=70, overflow=0, carry_out=1; out_valid rises exactly 4 edges after the accept edge.
- a=16777215, b=1, add -> overflow=1. sum=-16777216 with the macro undefined; sum=16777215 with CHUNKED_ADDER_SATURATE_EN.
- a=-16777216, b=1, sub=1 -> overflow=1. sum=16777215 wrapped; sum=-16777216 saturated. Also a=5, b=5, sub=1 -> sum=0, carry_out=1.
- Backpressure: hold out_ready=0 for 6 cycles in DONE with in_valid=1 and new operands -> outputs stable, in_ready=0, no new accept; one cycle after out_ready=1, in_ready=1.
- Pulse rst_n low mid-BUSY (after 2 chunks) -> all outputs 0 immediately; next operation a=3, b=4 gives sum=7 with normal latency.
- Parameter sweep CHUNK in {1, 7, 25} -> latency of 25, 4 and 1 BUSY cycles respectively. Random 1000-operation compare against an A±B reference model, including the sub and overflow cases.
